// File: rtl/float_mant_div_seq.sv
// Sequential restoring mantissa divider for the float divide path.
// Produces one quotient bit per clock, along with the sign and the biased exponent difference.
module float_mant_div_seq #(
   parameter int unsigned MANT_W     = 24,
   parameter int unsigned FRAC_SHIFT = 23,
   parameter int unsigned EXP_W      = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MANT_W-1:0]   a_mant,
   input  logic [MANT_W-1:0]   b_mant,
   input  logic [EXP_W-1:0]    a_exp,
   input  logic [EXP_W-1:0]    b_exp,
   input  logic                a_sign,
   input  logic                b_sign,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         quotient,
   output logic [MANT_W-1:0]   remainder,
   output logic                sign,
   output logic [EXP_W+1:0]    exp_diff,
   output logic                div_zero
);

   localparam int unsigned ITERS = MANT_W + FRAC_SHIFT;
   localparam int unsigned CNT_W = $clog2(ITERS);
   localparam int unsigned Q_W   = 32;
   localparam int unsigned ED_W  = EXP_W + 2;
   localparam logic [ED_W-1:0] BIAS = ED_W'((1 << (EXP_W - 1)) - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [ITERS-1:0]    dvd;
   logic [MANT_W-1:0]   dvs;
   logic [CNT_W-1:0]    cnt;
   logic [MANT_W:0]     trial;
   logic [MANT_W-1:0]   diff;
   logic                ge;

   // The remainder stays below the divisor, so the MANT_W-bit difference is exact whenever ge is set.
   assign trial = {remainder, dvd[ITERS-1]};
   assign ge    = (trial >= {1'b0, dvs});
   assign diff  = trial[MANT_W-1:0] - dvs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         sign      <= 1'b0;
         exp_diff  <= '0;
         div_zero  <= 1'b0;
         dvd       <= '0;
         dvs       <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready  <= 1'b0;
                  dvd       <= {a_mant, {FRAC_SHIFT{1'b0}}};
                  dvs       <= b_mant;
                  sign      <= a_sign ^ b_sign;
                  exp_diff  <= ED_W'(a_exp) - ED_W'(b_exp) + BIAS;
                  cnt       <= CNT_W'(ITERS - 1);
                  remainder <= '0;
                  if (b_mant == '0) begin
                     quotient <= '1;
                     div_zero <= 1'b1;
                     state    <= DONE;
                  end else begin
                     quotient <= '0;
                     div_zero <= 1'b0;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               dvd       <= dvd << 1;
               quotient  <= {quotient[Q_W-2:0], ge};
               remainder <= ge ? diff : trial[MANT_W-1:0];
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CNT_W'(1);
            end
            DONE: begin
               // out_valid rises one clock after entering DONE; the result then holds until it is consumed.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
